i2c_wb_seq: RTL and testbench
=============================

Name: i2c_wb_seq

Overview:
Wishbone master sequencer that sits directly upstream of i2c_master_top and drives its 8-bit register interface. It turns one byte-level command into the full register-access sequence: prescale/enable init, START, address, register, data, STOP. Single-byte register writes and random reads are supported, with TIP polling, RxACK checking and abort handling. It lets fabric logic access I2C slaves without a CPU.

Parameters:
PRESCALE, 16'd99, value written to PRERhi:PRERlo at init (wb_clk/(5*SCL)-1)
POLL_LIMIT, 16'd4095, max SR polls per byte before timeout abort

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  sequencer idle and initialised; accepts cmd on valid&ready
cmd_rw  in  1  0=write, 1=read
cmd_dev  in  7  7-bit slave address
cmd_reg  in  8  slave register index
cmd_wdata  in  8  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  8  read data (0 for writes/errors)
rsp_err  out  2  0=OK, 1=NACK, 2=arbitration lost, 3=timeout
wbm_adr_o  out  3  core register address
wbm_dat_o  out  8  write data to core
wbm_dat_i  in  8  read data from core
wbm_we_o  out  1  write enable
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_ack_i  in  1  ack from core

Behaviour:
- Clock wb_clk_i; reset wb_rst_i synchronous, active-high. Reset: all outputs 0, cmd_ready=0, FSM=INIT, poll counter 0. Reset mid-transfer drops cyc/stb the next edge; no STOP is issued.
- Bus access primitive: drive adr/dat/we with cyc=stb=1; hold until wbm_ack_i sampled high; on that edge clear cyc/stb and latch wbm_dat_i. Min one idle cycle between accesses. adr/dat/we stable while stb=1. No timeout on ack.
- INIT (once after reset): write adr0=PRESCALE[7:0], adr1=PRESCALE[15:8], adr2=0x80 (EN=1, IEN=0) -> IDLE, cmd_ready=1.
- IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch cmd_* and set cmd_ready=0 the next cycle.
- Byte step = write TXR (adr3) then CR (adr4), then POLL: read SR (adr4) repeatedly until SR[1] (TIP)=0. Then check SR[5] (AL) first, then SR[7] (RxACK) for write bytes.
- Write sequence: {dev,0}/CR=0x90 (STA|WR); reg/CR=0x10; wdata/CR=0x50 (STO|WR) -> RESP.
- Read sequence: {dev,0}/0x90; reg/0x10; {dev,1}/0x90 (repeated START); CR=0x68 (RD|ACK=NACK|STO), no TXR write; poll; read RXR (adr3) -> rsp_rdata -> RESP.
- AL=1 on any poll: abort immediately, no STOP, err=2.
- RxACK=1 on address/register/data byte: write CR=0x40 (STO), poll TIP=0, err=1. RxACK ignored on the final read byte.
- Poll counter resets at each byte step. If POLL_LIMIT reads see TIP=1: write CR=0x40, no further poll, err=3.
- RESP: rsp_valid=1 for exactly one cycle with rdata/err; rsp_rdata=0 unless read OK; next cycle -> IDLE. cmd_ready goes high the cycle after rsp_valid.
- cmd_* changes while busy are ignored. cmd_valid during INIT is held off (cmd_ready=0).
- Never asserts wbm_we_o on a read, never issues a CR write with both STA and RD set.

Test Plan:
- Reset then idle, PRESCALE=99: exactly 3 writes (adr0=0x63, adr1=0x00, adr2=0x80); cmd_ready rises after the third ack; no further bus activity.
- Write dev=0x50 reg=0x12 data=0xA5 with ACKing slave model: TXR/CR pairs 0xA0/0x90, 0x12/0x10, 0xA5/0x50; rsp_valid one cycle, rsp_err=0, rsp_rdata=0.
- Read dev=0x50 reg=0x34, slave returns 0x5C: CR sequence 0x90,0x10,0x90,0x68; TXR 0xA0,0x34,0xA1; rsp_rdata=0x5C, rsp_err=0.
- No slave at dev=0x27: RxACK=1 after the first byte; CR=0x40 issued; rsp_err=1; no register/data bytes sent.
- Forced AL=1 during the register byte poll: no CR=0x40 write; rsp_err=2 on the next response.
- SCL held low by the bench, POLL_LIMIT=8: exactly 8 SR reads, CR=0x40 written, rsp_err=3, then cmd_ready=1. wb_rst_i pulsed mid-poll: cyc/stb=0 the next cycle, and INIT is replayed.

Source files
------------

// File: rtl/i2c_wb_seq.sv
// Wishbone master sequencer for i2c_master_top: runs one single-byte register
// write or random read per command, with TIP polling, RxACK/AL checks and timeout.
module i2c_wb_seq #(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter logic [15:0] POLL_LIMIT = 16'd4095
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic       wbm_ack_i
);

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_INIT2, S_IDLE, S_TXR, S_CR, S_POLL,
    S_RXR, S_STOP_CR, S_STOP_POLL, S_RESP
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_AL   = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  state_t      state_reg, state_next;
  logic [1:0]  step_reg, step_next;
  logic [15:0] poll_cnt_reg, poll_cnt_next;
  logic [1:0]  err_reg, err_next;
  logic        rw_reg, rw_next;
  logic [6:0]  dev_reg, dev_next;
  logic [7:0]  regi_reg, regi_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic        cyc_reg, cyc_next;
  logic        we_reg, we_next;
  logic [2:0]  adr_reg, adr_next;
  logic [7:0]  dat_reg, dat_next;
  logic        cmd_ready_reg, rsp_valid_reg;
  logic [7:0]  rsp_rdata_reg;
  logic [1:0]  rsp_err_reg;

  logic [2:0]  req_adr;
  logic [7:0]  req_dat;
  logic        req_we;
  logic [7:0]  txr_val, cr_val;
  logic        ack_now, last_poll, bus_state;

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_cyc_o = cyc_reg;

  assign ack_now   = cyc_reg & wbm_ack_i;
  assign last_poll = (poll_cnt_reg == POLL_LIMIT - 16'd1);
  assign bus_state = (state_reg != S_IDLE) && (state_reg != S_RESP);

  // Byte step 2 is the repeated-START address on reads, the data byte on writes
  always_comb begin
    txr_val = {dev_reg, 1'b0};
    cr_val  = 8'h90;
    case (step_reg)
      2'd1: begin txr_val = regi_reg; cr_val = 8'h10; end
      2'd2: begin
        txr_val = rw_reg ? {dev_reg, 1'b1} : wdata_reg;
        cr_val  = rw_reg ? 8'h90 : 8'h50;
      end
      2'd3: begin txr_val = 8'h00; cr_val = 8'h68; end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    poll_cnt_next = poll_cnt_reg;
    err_next      = err_reg;
    rw_next       = rw_reg;
    dev_next      = dev_reg;
    regi_next     = regi_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    cyc_next      = cyc_reg;
    we_next       = we_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    req_adr       = 3'd4;
    req_dat       = 8'h00;
    req_we        = 1'b0;

    case (state_reg)
      S_INIT0:   begin req_adr = 3'd0; req_dat = PRESCALE[7:0];  req_we = 1'b1; end
      S_INIT1:   begin req_adr = 3'd1; req_dat = PRESCALE[15:8]; req_we = 1'b1; end
      S_INIT2:   begin req_adr = 3'd2; req_dat = 8'h80;          req_we = 1'b1; end
      S_TXR:     begin req_adr = 3'd3; req_dat = txr_val;        req_we = 1'b1; end
      S_CR:      begin req_adr = 3'd4; req_dat = cr_val;         req_we = 1'b1; end
      S_STOP_CR: begin req_adr = 3'd4; req_dat = 8'h40;          req_we = 1'b1; end
      S_RXR:     req_adr = 3'd3;
      default:   ;
    endcase

    // Launch on the cycle after entering a state, giving one idle cycle between accesses
    if (bus_state && !cyc_reg) begin
      cyc_next = 1'b1;
      adr_next = req_adr;
      dat_next = req_dat;
      we_next  = req_we;
    end
    if (ack_now) begin
      cyc_next = 1'b0;
      we_next  = 1'b0;
    end

    case (state_reg)
      S_INIT0: if (ack_now) state_next = S_INIT1;
      S_INIT1: if (ack_now) state_next = S_INIT2;
      S_INIT2: if (ack_now) state_next = S_IDLE;
      S_IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          rw_next    = cmd_rw;
          dev_next   = cmd_dev;
          regi_next  = cmd_reg;
          wdata_next = cmd_wdata;
          step_next  = 2'd0;
          err_next   = ERR_OK;
          rdata_next = 8'h00;
          state_next = S_TXR;
        end
      end
      S_TXR: if (ack_now) state_next = S_CR;
      S_CR: begin
        if (ack_now) begin
          poll_cnt_next = 16'd0;
          state_next    = S_POLL;
        end
      end
      S_POLL: begin
        if (ack_now) begin
          if (wbm_dat_i[1]) begin
            if (last_poll) begin
              err_next   = ERR_TMO;
              state_next = S_STOP_CR;
            end else begin
              poll_cnt_next = poll_cnt_reg + 16'd1;
            end
          end else if (wbm_dat_i[5]) begin
            err_next   = ERR_AL;
            state_next = S_RESP;
          end else if (step_reg == 2'd3) begin
            state_next = S_RXR;
          end else if (wbm_dat_i[7]) begin
            err_next   = ERR_NACK;
            state_next = S_STOP_CR;
          end else if (step_reg == 2'd2 && !rw_reg) begin
            state_next = S_RESP;
          end else begin
            step_next  = step_reg + 2'd1;
            state_next = (step_reg == 2'd2) ? S_CR : S_TXR;
          end
        end
      end
      S_RXR: begin
        if (ack_now) begin
          rdata_next = wbm_dat_i;
          state_next = S_RESP;
        end
      end
      S_STOP_CR: begin
        if (ack_now) begin
          poll_cnt_next = 16'd0;
          state_next    = (err_reg == ERR_TMO) ? S_RESP : S_STOP_POLL;
        end
      end
      S_STOP_POLL: begin
        if (ack_now) begin
          if (!wbm_dat_i[1] || last_poll) state_next = S_RESP;
          else poll_cnt_next = poll_cnt_reg + 16'd1;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_INIT0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= S_INIT0;
      step_reg      <= 2'd0;
      poll_cnt_reg  <= 16'd0;
      err_reg       <= ERR_OK;
      rw_reg        <= 1'b0;
      dev_reg       <= 7'd0;
      regi_reg      <= 8'h00;
      wdata_reg     <= 8'h00;
      rdata_reg     <= 8'h00;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= 3'd0;
      dat_reg       <= 8'h00;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 8'h00;
      rsp_err_reg   <= ERR_OK;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      poll_cnt_reg  <= poll_cnt_next;
      err_reg       <= err_next;
      rw_reg        <= rw_next;
      dev_reg       <= dev_next;
      regi_reg      <= regi_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      cyc_reg       <= cyc_next;
      we_reg        <= we_next;
      adr_reg       <= adr_next;
      dat_reg       <= dat_next;
      cmd_ready_reg <= (state_next == S_IDLE);
      rsp_valid_reg <= (state_next == S_RESP);
      rsp_err_reg   <= (state_next == S_RESP) ? err_next : ERR_OK;
      rsp_rdata_reg <= (state_next == S_RESP && err_next == ERR_OK && rw_reg) ? rdata_next : 8'h00;
    end
  end

endmodule

// File: tb/tb_i2c_wb_seq.sv
// Bench for i2c_wb_seq: a behavioural i2c_master_top register model answers the
// Wishbone bus, and each command's bus trace and response are checked against a list model.
module tb_i2c_wb_seq;
  localparam int POLL_LIM = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o, wbm_dat_i;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;

  i2c_wb_seq #(.PRESCALE(16'd99), .POLL_LIMIT(16'(POLL_LIM))) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] adr;
    logic       we;
    logic [7:0] dat;
  } op_t;

  op_t log_q[$];
  op_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Core behaviour knobs: busy polls per byte, stuck SCL, byte index reporting AL/NACK
  int         m_busy  = 0;
  int         m_al    = -1;
  int         m_nack  = -1;
  bit         m_stuck = 1'b0;
  logic [7:0] m_rx    = 8'h00;
  int         byte_idx = 0;
  int         polls    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Register-level core model with 0..2 cycles of ack latency
  initial begin : core_model
    int  dly;
    int  cur;
    bit  tip;
    op_t op;
    dly = 0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (dly > 0) begin
          dly--;
        end else begin
          op.adr = wbm_adr_o;
          op.we  = wbm_we_o;
          op.dat = wbm_we_o ? wbm_dat_o : 8'h00;
          wbm_dat_i = 8'h00;
          if (wbm_we_o) begin
            if (wbm_adr_o == 3'd4) begin
              byte_idx++;
              polls = 0;
            end
          end else if (wbm_adr_o == 3'd4) begin
            tip = m_stuck || (polls < m_busy);
            polls++;
            cur = byte_idx - 1;
            wbm_dat_i = {(!tip && cur == m_nack), 1'b0, (!tip && cur == m_al), 3'b000, tip, 1'b0};
          end else if (wbm_adr_o == 3'd3) begin
            wbm_dat_i = m_rx;
          end
          log_q.push_back(op);
          wbm_ack_i = 1'b1;
          dly = $urandom_range(0, 2);
        end
      end
    end
  end

  function automatic void push(input logic [2:0] a, input logic w, input logic [7:0] d);
    exp_q.push_back({a, w, d});
  endfunction

  // Expected bus trace and response, derived from the byte-step rules
  task automatic build_exp(input bit rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, output logic [1:0] e_err, output logic [7:0] e_rd);
    logic [7:0] txr[4];
    logic [7:0] cr[4];
    int nbytes;
    exp_q.delete();
    txr[0] = {dev, 1'b0}; cr[0] = 8'h90;
    txr[1] = rg;          cr[1] = 8'h10;
    txr[3] = 8'h00;       cr[3] = 8'h68;
    if (rw) begin txr[2] = {dev, 1'b1}; cr[2] = 8'h90; nbytes = 4; end
    else    begin txr[2] = wd;          cr[2] = 8'h50; nbytes = 3; end
    e_err = 2'd0;
    e_rd  = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      if (i < 3) push(3'd3, 1'b1, txr[i]);
      push(3'd4, 1'b1, cr[i]);
      if (m_stuck) begin
        repeat (POLL_LIM) push(3'd4, 1'b0, 8'h00);
        push(3'd4, 1'b1, 8'h40);
        e_err = 2'd3;
        return;
      end
      repeat (m_busy + 1) push(3'd4, 1'b0, 8'h00);
      if (i == m_al) begin e_err = 2'd2; return; end
      if (i == 3) begin push(3'd3, 1'b0, 8'h00); e_rd = m_rx; return; end
      if (i == m_nack) begin
        push(3'd4, 1'b1, 8'h40);
        repeat (m_busy + 1) push(3'd4, 1'b0, 8'h00);
        e_err = 2'd1;
        return;
      end
    end
  endtask

  task automatic compare_log(input string tag);
    check({tag, " op count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s op%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic expect_init(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    check({tag, " ready low"}, cmd_ready, 1'b0);
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check({tag, " ready"}, cmd_ready, 1'b1);
    exp_q.delete();
    push(3'd0, 1'b1, 8'h63);
    push(3'd1, 1'b1, 8'h00);
    push(3'd2, 1'b1, 8'h80);
    compare_log(tag);
  endtask

  task automatic do_cmd(input string tag, input bit rw, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [7:0] wd);
    logic [1:0] e_err;
    logic [7:0] e_rd;
    int n;
    bit seen;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check({tag, " ready"}, cmd_ready, 1'b1);
    byte_idx = 0;
    polls = 0;
    log_q.delete();
    build_exp(rw, dev, rg, wd, e_err, e_rd);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rw = 1'($urandom); cmd_dev = 7'($urandom); cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);
    check({tag, " busy"}, cmd_ready, 1'b0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 3000) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      else begin @(negedge clk); n++; end
    end
    check({tag, " rsp seen"}, seen, 1'b1);
    if (seen) begin
      check({tag, " rsp_err"}, rsp_err, e_err);
      check({tag, " rsp_rdata"}, rsp_rdata, e_rd);
      @(negedge clk);
      check({tag, " rsp one cycle"}, rsp_valid, 1'b0);
      check({tag, " ready after rsp"}, cmd_ready, 1'b1);
    end
    compare_log(tag);
    $display("[TB] %s rw=%0d dev=0x%02h reg=0x%02h wd=0x%02h -> err=%0d rdata=0x%02h ops=%0d",
             tag, rw, dev, rg, wd, rsp_err, rsp_rdata, log_q.size());
  endtask

  initial begin : stimulus
    int n;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev = 7'd0; cmd_reg = 8'h00; cmd_wdata = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1'b0);
    check("reset cyc", wbm_cyc_o, 1'b0);
    check("reset stb", wbm_stb_o, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset we", wbm_we_o, 1'b0);
    log_q.delete();
    rst = 1'b0;
    expect_init("init");
    repeat (20) @(negedge clk);
    check("init quiet ops", log_q.size(), 3);
    check("init quiet cyc", wbm_cyc_o, 1'b0);

    m_busy = 1; m_al = -1; m_nack = -1; m_stuck = 1'b0;
    do_cmd("write", 1'b0, 7'h50, 8'h12, 8'hA5);

    m_busy = 2; m_rx = 8'h5C;
    do_cmd("read", 1'b1, 7'h50, 8'h34, 8'h00);

    m_busy = 0; m_nack = 0;
    do_cmd("nack", 1'b0, 7'h27, 8'h01, 8'h02);

    m_busy = 1; m_nack = -1; m_al = 1;
    do_cmd("arb lost", 1'b1, 7'h50, 8'h34, 8'h00);

    m_al = -1; m_stuck = 1'b1;
    do_cmd("timeout", 1'b0, 7'h50, 8'h12, 8'h33);
    m_stuck = 1'b0;

    for (int k = 0; k < 16; k++) begin
      int v;
      m_busy = $urandom_range(0, 3);
      v = $urandom_range(0, 9);  m_al   = (v < 4) ? v : -1;
      v = $urandom_range(0, 7);  m_nack = (v < 4) ? v : -1;
      m_rx = 8'($urandom);
      do_cmd($sformatf("rand%0d", k), 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    end

    // Reset while polling: bus must drop at once and init replays
    m_al = -1; m_nack = -1; m_stuck = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    byte_idx = 0; polls = 0; log_q.delete();
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev = 7'h11; cmd_reg = 8'h22; cmd_wdata = 8'h33;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (log_q.size() < 4 && n < 200) begin @(negedge clk); n++; end
    check("midpoll reached", log_q.size() >= 4, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midpoll rst cyc", wbm_cyc_o, 1'b0);
    check("midpoll rst stb", wbm_stb_o, 1'b0);
    @(negedge clk);
    m_stuck = 1'b0;
    log_q.delete();
    rst = 1'b0;
    expect_init("reinit");
    $display("[TB] reset mid-poll: init replayed with %0d ops", log_q.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
